uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx_if.sv | 12 +
 rtl/uart_tx.sv | 158 +++++++++++++++
 tb/tb_uart_tx.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Read-side handshake between an upstream first-word-fall-through FIFO and uart_tx.
// master = FIFO side, slave = transmitter side.
interface uart_tx_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_data;
  logic                 fifo_rd;

  modport master (output fifo_empty, output fifo_data, input fifo_rd);
  modport slave  (input fifo_empty, input fifo_data, output fifo_rd);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: pops words from a FWFT FIFO and serialises start/data/stop at 16x s_tick.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned SB_TICK   = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     s_tick,
  uart_tx_if.slave fifo,
  output logic     tx,
  output logic     tx_busy,
  output logic     tx_done_tick
);
  // Tick counter widens beyond 4 bits only when the stop bit spans more than 16 ticks.
  localparam int unsigned TW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] BIT_LAST  = TW'(15);
  localparam logic [TW-1:0] STOP_LAST = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t               r_state, w_state;
  logic [TW-1:0]        r_tick,  w_tick;
  logic [BW-1:0]        r_bit,   w_bit;
  logic [DATA_BITS-1:0] r_shift, w_shift;
  logic                 r_tx,    w_tx;
  logic                 w_rd, w_done;
`ifdef UART_TX_PARITY_EN
  logic                 r_par,   w_par;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state;
      r_tick  <= w_tick;
      r_bit   <= w_bit;
      r_shift <= w_shift;
      r_tx    <= w_tx;
`ifdef UART_TX_PARITY_EN
      r_par   <= w_par;
`endif
    end
  end

  // w_tx is the value the line takes on the edge that enters the next state or bit.
  always_comb begin
    w_state = r_state;
    w_tick  = r_tick;
    w_bit   = r_bit;
    w_shift = r_shift;
    w_tx    = r_tx;
    w_rd    = 1'b0;
    w_done  = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_par   = r_par;
`endif
    case (r_state)
      IDLE: begin
        w_tx = 1'b1;
        if (!fifo.fifo_empty) begin
          w_rd    = 1'b1;
          w_shift = fifo.fifo_data;
          w_tick  = '0;
          w_state = START;
          w_tx    = 1'b0;
`ifdef UART_TX_PARITY_EN
          w_par   = ^fifo.fifo_data;
`endif
        end
      end
      START: begin
        if (s_tick) begin
          if (r_tick == BIT_LAST) begin
            w_tick  = '0;
            w_bit   = '0;
            w_state = DATA;
            w_tx    = r_shift[0];
          end else begin
            w_tick = r_tick + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (r_tick == BIT_LAST) begin
            w_tick  = '0;
            w_shift = r_shift >> 1;
            if (r_bit == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
              w_state = PARITY;
              w_tx    = r_par;
`else
              w_state = STOP;
              w_tx    = 1'b1;
`endif
            end else begin
              w_bit = r_bit + 1'b1;
              w_tx  = w_shift[0];
            end
          end else begin
            w_tick = r_tick + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (r_tick == BIT_LAST) begin
            w_tick  = '0;
            w_state = STOP;
            w_tx    = 1'b1;
          end else begin
            w_tick = r_tick + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (r_tick == STOP_LAST) begin
            w_tick  = '0;
            w_done  = 1'b1;
            w_state = IDLE;
            w_tx    = 1'b1;
          end else begin
            w_tick = r_tick + 1'b1;
          end
        end
      end
      default: begin
        w_state = IDLE;
        w_tx    = 1'b1;
      end
    endcase
  end

  // State already sits in IDLE during reset, so the pop strobe must be gated by rst_n itself.
  assign fifo.fifo_rd  = w_rd & rst_n;
  assign tx_done_tick  = w_done;
  assign tx            = r_tx;
  assign tx_busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: queued words are compared tick by tick against the serial line.
`timescale 1ns/1ps
module tb_uart_tx;
  localparam int unsigned DB = 8;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned P = 1;
`else
  localparam int unsigned P = 0;
`endif
  localparam int unsigned LEN   = (1 + DB + P) * 16 + 16;
  localparam int unsigned LEN32 = (1 + DB + P) * 16 + 32;
  localparam int unsigned TDIV  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_tick = 1'b0;
  logic tx, tx_busy, tx_done_tick;
  logic tx2, tx2_busy, tx2_done;

  uart_tx_if #(.DATA_BITS(DB)) ifc ();
  uart_tx_if #(.DATA_BITS(DB)) ifc2 ();

  logic [DB-1:0] mem  [16];
  logic [DB-1:0] mem2 [16];
  logic [3:0]    wp = '0, rp = '0, wp2 = '0, rp2 = '0;

  assign ifc.fifo_empty  = (wp == rp);
  assign ifc.fifo_data   = mem[rp];
  assign ifc2.fifo_empty = (wp2 == rp2);
  assign ifc2.fifo_data  = mem2[rp2];
  always @(posedge clk) if (ifc.fifo_rd)  rp  <= rp + 4'd1;
  always @(posedge clk) if (ifc2.fifo_rd) rp2 <= rp2 + 4'd1;

  uart_tx #(.DATA_BITS(DB), .SB_TICK(16)) dut (
    .clk(clk), .rst_n(rst_n), .s_tick(s_tick), .fifo(ifc),
    .tx(tx), .tx_busy(tx_busy), .tx_done_tick(tx_done_tick)
  );
  uart_tx #(.DATA_BITS(DB), .SB_TICK(32)) dut2 (
    .clk(clk), .rst_n(rst_n), .s_tick(s_tick), .fifo(ifc2),
    .tx(tx2), .tx_busy(tx2_busy), .tx_done_tick(tx2_done)
  );

  always #5 clk = ~clk;

  initial begin : g_tick
    int unsigned k;
    k = 0;
    forever begin
      @(posedge clk); #1;
      k = (k + 1) % TDIV;
      s_tick = (k == 0);
    end
  end

  int unsigned vectors = 0, miscompares = 0;
  int unsigned cyc = 0, rd_cnt = 0, done_cnt = 0, nprint = 0;
  int unsigned m_n = 0, start_cyc = 0, done_cyc = 0, last_gap = 0;
  logic        m_busy = 1'b0;
  logic [DB-1:0] m_word;
  logic [DB-1:0] sb [$];

  function automatic logic exp_bit(input logic [DB-1:0] w, input int unsigned idx);
    if (idx == 0) return 1'b0;
    if (idx <= DB) return w[idx-1];
    if (P == 1 && idx == DB + 1) return ^w;
    return 1'b1;
  endfunction

  // Line monitor: pops the scoreboard at each start bit and checks every counted tick.
  initial begin : g_mon
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        m_busy = 1'b0;
      end else begin
        if (ifc.fifo_rd === 1'b1) begin
          rd_cnt++;
          vectors++;
          if (tx_busy !== 1'b0) begin
            miscompares++;
            if (nprint++ < 20) $display("FAIL rd_in_frame: tx_busy=%b required 0 (cycle %0d)", tx_busy, cyc);
          end
        end
        if (!m_busy && tx === 1'b0) begin
          m_busy = 1'b1; m_n = 0;
          last_gap = cyc - done_cyc; start_cyc = cyc;
          vectors++;
          if (sb.size() == 0) begin
            miscompares++; m_word = '0;
            if (nprint++ < 20) $display("FAIL frame_expected: start bit with empty scoreboard, required none");
          end else begin
            m_word = sb.pop_front();
          end
        end
        if (m_busy) begin
          vectors++;
          if (tx_busy !== 1'b1) begin
            miscompares++;
            if (nprint++ < 20) $display("FAIL busy_in_frame: tx_busy=%b required 1 (tick %0d)", tx_busy, m_n);
          end
          if (s_tick) begin
            m_n++;
            if (m_n <= LEN) begin
              vectors++;
              if (tx !== exp_bit(m_word, (m_n - 1) / 16)) begin
                miscompares++;
                if (nprint++ < 20) $display("FAIL tx_bit: word %h tick %0d tx=%b required %b",
                                            m_word, m_n, tx, exp_bit(m_word, (m_n - 1) / 16));
              end
            end
          end
          if (tx_done_tick === 1'b1) begin
            vectors++;
            if (m_n != LEN) begin
              miscompares++;
              if (nprint++ < 20) $display("FAIL frame_len: word %h got %0d ticks required %0d", m_word, m_n, LEN);
            end
            done_cnt++; done_cyc = cyc; m_busy = 1'b0;
          end else if (m_n > LEN) begin
            vectors++; miscompares++; m_busy = 1'b0;
            if (nprint++ < 20) $display("FAIL frame_overrun: word %h no done after %0d ticks required %0d", m_word, m_n, LEN);
          end
        end else begin
          vectors++;
          if (tx_done_tick !== 1'b0 || tx_busy !== 1'b0) begin
            miscompares++;
            if (nprint++ < 20) $display("FAIL idle_outputs: done=%b busy=%b required 0 0 (cycle %0d)", tx_done_tick, tx_busy, cyc);
          end
        end
      end
    end
  end

  task automatic push(input logic [DB-1:0] w);
    mem[wp] = w; wp = wp + 4'd1; sb.push_back(w);
  endtask

  task automatic wait_done(input int unsigned target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (done_cnt >= target) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    vectors++; if (tx !== 1'b1)           begin miscompares++; $display("FAIL reset_tx: got %b required 1", tx); end
    vectors++; if (tx_busy !== 1'b0)      begin miscompares++; $display("FAIL reset_busy: got %b required 0", tx_busy); end
    vectors++; if (tx_done_tick !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b required 0", tx_done_tick); end
    vectors++; if (tx2 !== 1'b1)          begin miscompares++; $display("FAIL reset_tx2: got %b required 1", tx2); end
    push(8'h55);
    #1;
    vectors++; if (ifc.fifo_rd !== 1'b0)  begin miscompares++; $display("FAIL reset_rd: got %b required 0", ifc.fifo_rd); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    vectors++; if (ifc.fifo_rd !== 1'b1)  begin miscompares++; $display("FAIL release_rd: got %b required 1", ifc.fifo_rd); end
  endtask

  task automatic test_single_frame();
    bit ok;
    wait_done(1, ok);
    vectors++; if (!ok)         begin miscompares++; $display("FAIL single_done: timeout, done count %0d required 1", done_cnt); end
    vectors++; if (rd_cnt != 1) begin miscompares++; $display("FAIL single_rd: got %0d pops required 1", rd_cnt); end
    repeat (3) @(negedge clk); #1;
    vectors++; if (tx !== 1'b1 || tx_busy !== 1'b0) begin
      miscompares++; $display("FAIL single_after: tx=%b busy=%b required 1 0", tx, tx_busy);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int unsigned rd0, d0;
    rd0 = rd_cnt; d0 = done_cnt;
    @(posedge clk); #1;
    push(8'hA5); push(8'h3C);
    wait_done(d0 + 2, ok);
    vectors++; if (!ok)                begin miscompares++; $display("FAIL b2b_done: timeout, done %0d required %0d", done_cnt, d0 + 2); end
    vectors++; if (rd_cnt - rd0 != 2)  begin miscompares++; $display("FAIL b2b_rd: got %0d pops required 2", rd_cnt - rd0); end
    vectors++; if (last_gap != 2)      begin miscompares++; $display("FAIL b2b_gap: start %0d clk after done required 2", last_gap); end
    vectors++; if (sb.size() != 0)     begin miscompares++; $display("FAIL b2b_queue: %0d words left required 0", sb.size()); end
  endtask

  task automatic test_idle();
    int unsigned rd0, d0, np;
    rd0 = rd_cnt; d0 = done_cnt; np = 0;
    for (int i = 0; i < 1000 * TDIV; i++) begin
      @(negedge clk); #1;
      vectors++;
      if (tx !== 1'b1 || tx_busy !== 1'b0 || ifc.fifo_rd !== 1'b0) begin
        miscompares++;
        if (np++ < 5) $display("FAIL idle_hold: tx=%b busy=%b rd=%b required 1 0 0", tx, tx_busy, ifc.fifo_rd);
      end
    end
    vectors++; if (rd_cnt != rd0 || done_cnt != d0) begin
      miscompares++; $display("FAIL idle_events: pops %0d dones %0d required 0 0", rd_cnt - rd0, done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok, hit;
    int unsigned d0;
    d0 = done_cnt; hit = 1'b0;
    @(posedge clk); #1;
    push(8'hFF);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk); #1;
      if (m_busy && m_n >= 16 * 4 + 4) begin hit = 1'b1; break; end
    end
    vectors++; if (!hit) begin miscompares++; $display("FAIL rmid_reach: data bit 3 not reached, tick %0d required 68", m_n); end
    rst_n = 1'b0;
    #1;
    vectors++; if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done_tick !== 1'b0 || ifc.fifo_rd !== 1'b0) begin
      miscompares++; $display("FAIL rmid_force: tx=%b busy=%b done=%b rd=%b required 1 0 0 0", tx, tx_busy, tx_done_tick, ifc.fifo_rd);
    end
    repeat (4) @(posedge clk);
    #1; rst_n = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    vectors++; if (done_cnt != d0) begin miscompares++; $display("FAIL rmid_nodone: dones %0d required 0", done_cnt - d0); end
    vectors++; if (tx !== 1'b1 || tx_busy !== 1'b0) begin
      miscompares++; $display("FAIL rmid_idle: tx=%b busy=%b required 1 0", tx, tx_busy);
    end
    @(posedge clk); #1;
    push(8'h96);
    #1;
    vectors++; if (ifc.fifo_rd !== 1'b1) begin miscompares++; $display("FAIL rmid_restart_rd: got %b required 1", ifc.fifo_rd); end
    wait_done(d0 + 1, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL rmid_restart: timeout, done %0d required %0d", done_cnt, d0 + 1); end
  endtask

  task automatic test_parity();
    bit ok;
    int unsigned rd0, d0;
    rd0 = rd_cnt; d0 = done_cnt;
    @(posedge clk); #1;
    push(8'h07); push(8'h03);
    wait_done(d0 + 2, ok);
    vectors++; if (!ok)               begin miscompares++; $display("FAIL parity_done: timeout, done %0d required %0d", done_cnt, d0 + 2); end
    vectors++; if (rd_cnt - rd0 != 2) begin miscompares++; $display("FAIL parity_rd: got %0d pops required 2", rd_cnt - rd0); end
  endtask

  task automatic test_sb32();
    bit found, got;
    int unsigned n, np;
    logic e;
    found = 1'b0; got = 1'b0; n = 0; np = 0;
    @(posedge clk); #1;
    mem2[wp2] = 8'h00; wp2 = wp2 + 4'd1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx2 === 1'b0) begin found = 1'b1; break; end
    end
    vectors++; if (!found) begin miscompares++; $display("FAIL sb32_start: tx2=%b required 0", tx2); end
    for (int i = 0; i < 4000 && found; i++) begin
      if (i > 0) @(negedge clk);
      if (s_tick) begin
        n++;
        e = (n <= (1 + DB + P) * 16) ? 1'b0 : 1'b1;
        vectors++;
        if (tx2 !== e) begin
          miscompares++;
          if (np++ < 5) $display("FAIL sb32_bit: tick %0d tx2=%b required %b", n, tx2, e);
        end
      end
      if (tx2_done === 1'b1) begin got = 1'b1; break; end
      if (n > LEN32) break;
    end
    vectors++; if (!got || n != LEN32) begin
      miscompares++; $display("FAIL sb32_len: done=%b ticks %0d required %0d", got, n, LEN32);
    end
  endtask

  initial begin : g_watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : g_main
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_idle();
    test_reset_mid_frame();
    test_parity();
    test_sb32();
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
